match_capture: RTL and testbench

//  Downstream of the comparator in the bus sniffer. Consumes its one-cycle

---
 rtl/match_capture.sv | 136 +++++++++++++
 tb/tb_match_capture.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/match_capture.sv
// match_capture: timestamps comparator match pulses and queues
// {timestamp, bus value} entries in a FIFO for software readout. Counts hits
// per session and raises a sticky trigger at a programmed hit count, after
// which capture stops until re-armed.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   clear               sync flush of FIFO, count and flags; returns to IDLE
//   arm                 sync pulse starting (or restarting) a capture session
//   enable, match       capture qualifier and comparator result pulse
//   data                bus value fed to the comparator (unregistered)
//   threshold           hits required to trigger (0 behaves as 1)
//   rd_valid/rd_ready   FIFO head handshake
//   rd_data, rd_ts      head entry bus value and timestamp (zero when empty)
//   match_count         saturating hit count this session
//   triggered, overflow sticky flags
//   busy                session armed and capturing
module match_capture #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 arm,
  input  logic                 enable,
  input  logic                 match,
  input  logic [WIDTH-1:0]     data,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [TS_WIDTH-1:0]  rd_ts,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 triggered,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PCW   = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ARMED, TRIG} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     data_q;
  logic [TS_WIDTH-1:0]  ts;
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic [WIDTH-1:0]     mem_data [DEPTH];
  logic [TS_WIDTH-1:0]  mem_ts   [DEPTH];
  logic                 empty, full, hit, pop, push, thr_reached;
  logic [CNT_WIDTH-1:0] count_inc, thr_eff;

  // FIFO status; extra pointer bit distinguishes full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && rd_ready;

  // clear and arm both outrank a same-cycle hit
  assign hit  = match && enable && (state == ARMED) && !clear && !arm;
  assign push = hit && (!full || pop);

  assign count_inc   = (match_count == '1) ? match_count : match_count + CNT_WIDTH'(1);
  assign thr_eff     = (threshold == '0) ? CNT_WIDTH'(1) : threshold;
  // >= so a threshold lowered below the running count fires on the next hit
  assign thr_reached = (count_inc >= thr_eff);

  // Head is shown straight from storage; empty reads as zero
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_data[rd_ptr[PTR_W-1:0]];
  assign rd_ts    = empty ? '0 : mem_ts[rd_ptr[PTR_W-1:0]];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (clear)                    state_next = IDLE;
    else if (arm)                 state_next = ARMED;
    else if (hit && thr_reached)  state_next = TRIG;
  end

  // Datapath: alignment delay, timestamp, counters, flags, pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      match_count <= '0;
      triggered   <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // comparator result lags its B input by one cycle
      data_q <= data;
      busy   <= (state_next == ARMED);
      ts     <= (arm && !clear) ? '0 : ts + TS_WIDTH'(1);
      if (clear) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        match_count <= '0;
        triggered   <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (arm) begin
          match_count <= '0;
          triggered   <= 1'b0;
          overflow    <= 1'b0;
        end else if (hit) begin
          match_count <= count_inc;
          if (thr_reached)  triggered <= 1'b1;
          if (full && !pop) overflow  <= 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + PCW'(1);
        if (pop)  rd_ptr <= rd_ptr + PCW'(1);
      end
    end
  end

  // Entry storage, not reset; reads are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[PTR_W-1:0]] <= data_q;
      mem_ts[wr_ptr[PTR_W-1:0]]   <= ts;
    end
  end

endmodule

// File: tb/tb_match_capture.sv
// tb_match_capture: table-driven vectors plus hand sequences for FIFO
// overflow and asynchronous reset of match_capture.
module tb_match_capture;

  logic        clk = 1'b0;
  logic        reset, clear, arm, enable, match, rd_ready;
  logic [31:0] data;
  logic [15:0] threshold;
  logic        rd_valid, triggered, overflow, busy;
  logic [31:0] rd_data;
  logic [15:0] rd_ts, match_count;

  int checks = 0;
  int errors = 0;

  match_capture dut (
    .clk(clk), .reset(reset), .clear(clear), .arm(arm), .enable(enable),
    .match(match), .data(data), .threshold(threshold), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_ts(rd_ts),
    .match_count(match_count), .triggered(triggered), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm, clr, en, m, rdy;
    logic [15:0] thr;
    logic [31:0] data;
    logic        ev;
    logic [31:0] ed;
    logic [15:0] ets, ec;
    logic        et, eo, eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic a, logic c, logic e, logic m, logic r,
                              logic [15:0] thr, logic [31:0] d, logic ev,
                              logic [31:0] ed, logic [15:0] ets, logic [15:0] ec,
                              logic et, logic eo, logic eb);
    vec_t v;
    v.arm = a; v.clr = c; v.en = e; v.m = m; v.rdy = r; v.thr = thr; v.data = d;
    v.ev = ev; v.ed = ed; v.ets = ets; v.ec = ec; v.et = et; v.eo = eo; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic a, logic c, logic e, logic m, logic r,
                       logic [15:0] thr, logic [31:0] d);
    arm = a; clear = c; enable = e; match = m; rd_ready = r; threshold = thr; data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] last;
    reset = 1'b0;
    drive(0, 0, 1, 0, 0, 16'd3, 32'h0);

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rd_valid", 32'(rd_valid), 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.rd_ts", 32'(rd_ts), 0);
    chk("rst.count", 32'(match_count), 0);
    chk("rst.flags", {29'd0, triggered, overflow, busy}, 0);
    reset = 1'b1;
    step();

    // ---- table: arm clr en m rdy thr data | ev ed ets ec et eo eb ----
    // threshold 3, three hits A1/A2/A3, extra hit ignored, drain in order
    vq.push_back(mk(1,0,1,0,0, 3, 32'h0,  0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,1,0,0, 3, 32'hA1, 0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 3, 32'hA2, 1, 32'hA1, 1, 1, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 3, 32'hA3, 1, 32'hA1, 1, 2, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 3, 32'h0,  1, 32'hA1, 1, 3, 1,0,0));
    vq.push_back(mk(0,0,1,1,0, 3, 32'h55, 1, 32'hA1, 1, 3, 1,0,0));
    vq.push_back(mk(0,0,1,0,1, 3, 32'h0,  1, 32'hA2, 2, 3, 1,0,0));
    vq.push_back(mk(0,0,1,0,1, 3, 32'h0,  1, 32'hA3, 3, 3, 1,0,0));
    vq.push_back(mk(0,0,1,0,1, 3, 32'h0,  0, 32'h0,  0, 3, 1,0,0));
    vq.push_back(mk(0,0,1,0,1, 3, 32'h0,  0, 32'h0,  0, 3, 1,0,0));
    // threshold 0 acts as 1
    vq.push_back(mk(1,0,1,0,0, 0, 32'h0,  0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,1,0,0, 0, 32'hB1, 0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 0, 32'h0,  1, 32'hB1, 1, 1, 1,0,0));
    vq.push_back(mk(0,0,1,0,1, 0, 32'h0,  0, 32'h0,  0, 1, 1,0,0));
    // enable low, then hits while IDLE
    vq.push_back(mk(1,0,1,0,0, 5, 32'h0,  0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,0,1,0, 5, 32'hC1, 0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,1,1,0,0, 5, 32'h0,  0, 32'h0,  0, 0, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 5, 32'hC2, 0, 32'h0,  0, 0, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 5, 32'h0,  0, 32'h0,  0, 0, 0,0,0));
    // one entry, then clear+arm+hit together
    vq.push_back(mk(1,0,1,0,0, 5, 32'hD1, 0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 5, 32'h0,  1, 32'hD1, 0, 1, 0,0,1));
    vq.push_back(mk(1,1,1,1,0, 5, 32'h0,  0, 32'h0,  0, 0, 0,0,0));
    // arm beats same-cycle hit; lowering threshold fires on next hit only
    vq.push_back(mk(1,0,1,0,0, 5, 32'h0,  0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(1,0,1,1,0, 5, 32'hE1, 0, 32'h0,  0, 0, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 5, 32'h0,  1, 32'hE1, 0, 1, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 5, 32'h0,  1, 32'hE1, 0, 2, 0,0,1));
    vq.push_back(mk(0,0,1,0,0, 1, 32'h0,  1, 32'hE1, 0, 2, 0,0,1));
    vq.push_back(mk(0,0,1,1,0, 1, 32'h0,  1, 32'hE1, 0, 3, 1,0,0));
    vq.push_back(mk(0,1,1,0,0, 1, 32'h0,  0, 32'h0,  0, 0, 0,0,0));

    foreach (vq[i]) begin
      drive(vq[i].arm, vq[i].clr, vq[i].en, vq[i].m, vq[i].rdy, vq[i].thr, vq[i].data);
      step();
      chk($sformatf("v%0d.rd_valid", i), 32'(rd_valid), 32'(vq[i].ev));
      chk($sformatf("v%0d.rd_data", i), rd_data, vq[i].ed);
      chk($sformatf("v%0d.rd_ts", i), 32'(rd_ts), 32'(vq[i].ets));
      chk($sformatf("v%0d.count", i), 32'(match_count), 32'(vq[i].ec));
      chk($sformatf("v%0d.triggered", i), 32'(triggered), 32'(vq[i].et));
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vq[i].eo));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vq[i].eb));
    end

    // ---- 18 hits into a 16-deep FIFO, then hit+pop while full ----
    drive(1, 0, 1, 0, 0, 16'd100, 32'h100);
    step();
    for (int i = 0; i < 18; i++) begin
      drive(0, 0, 1, 1, 0, 16'd100, 32'(i + 1));
      step();
      if (i == 15) chk("ovf.before_drop", 32'(overflow), 0);
      if (i == 16) chk("ovf.first_drop", 32'(overflow), 1);
    end
    chk("ovf.count18", 32'(match_count), 18);
    chk("ovf.busy", 32'(busy), 1);
    chk("ovf.head_data", rd_data, 32'h100);
    chk("ovf.head_ts", 32'(rd_ts), 0);
    drive(0, 0, 1, 1, 1, 16'd100, 32'h0);
    step();
    chk("ovf.count19", 32'(match_count), 19);
    chk("ovf.head_after_pop", rd_data, 32'h1);
    chk("ovf.ts_after_pop", 32'(rd_ts), 1);
    drive(0, 0, 1, 0, 1, 16'd100, 32'h0);
    n = 0;
    last = '0;
    while (rd_valid && n < 20) begin
      last = rd_data;
      step();
      n++;
    end
    chk("ovf.entries", 32'(n), 16);
    chk("ovf.last_entry", last, 32'd18);
    chk("ovf.empty", 32'(rd_valid), 0);

    // ---- async reset mid-session with 5 entries ----
    drive(0, 1, 1, 0, 0, 16'd100, 32'h0);
    step();
    drive(1, 0, 1, 0, 0, 16'd100, 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0, 16'd100, 32'(i + 32'h70));
      step();
    end
    chk("rst6.pre_valid", 32'(rd_valid), 1);
    chk("rst6.pre_count", 32'(match_count), 5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst6.rd_valid", 32'(rd_valid), 0);
    chk("rst6.count", 32'(match_count), 0);
    chk("rst6.flags", {29'd0, triggered, overflow, busy}, 0);
    chk("rst6.rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 1, 0, 16'd100, 32'h0);
    step();
    chk("rst6.idle_after", {30'd0, rd_valid, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
